// File: rtl/hand_datapath_if.sv
// ---------------------------------------------------------------------------
// hand_datapath_if
//   Card-load and hand-readout bus between the baccarat dealing controller
//   (master) and the hand datapath (slave). The master presents a card code
//   and one load strobe per card; the slave returns the registered cards, the
//   two hand scores, the dealt count and the sticky order-violation flag.
// ---------------------------------------------------------------------------
interface hand_datapath_if;

  // Controller -> datapath
  logic [3:0] new_card;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;

  // Datapath -> controller / display
  logic [3:0] pcard1_out;
  logic [3:0] pcard2_out;
  logic [3:0] pcard3_out;
  logic [3:0] dcard1_out;
  logic [3:0] dcard2_out;
  logic [3:0] dcard3_out;
  logic [3:0] pcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [2:0] cards_dealt;
  logic       protocol_err;

  modport master (
    output new_card,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    input  pcard1_out, pcard2_out, pcard3_out,
    input  dcard1_out, dcard2_out, dcard3_out,
    input  pcard3, pscore, dscore, cards_dealt, protocol_err
  );

  modport slave (
    input  new_card,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    output pcard1_out, pcard2_out, pcard3_out,
    output dcard1_out, dcard2_out, dcard3_out,
    output pcard3, pscore, dscore, cards_dealt, protocol_err
  );

endinterface : hand_datapath_if

// File: rtl/hand_datapath.sv
// ---------------------------------------------------------------------------
// hand_datapath
//   Holds the six cards of one baccarat hand (player 1-3, dealer 1-3),
//   enforces the dealing order P1, D1, P2, D2, then P3 followed by D3 or
//   D3 alone, and reports the two hand scores (sum of card values mod 10).
//   Any out-of-order or multiple load is refused and latches protocol_err
//   until reset; legal loads keep being accepted afterwards.
//
//   Optional build macro HAND_INTERNAL_DEALER_EN: cards are taken from an
//   internal free-running 1..CARD_MAX counter instead of new_card.
//
//   Reset: resetb, synchronous, active-low, on slow_clock rising edge.
// ---------------------------------------------------------------------------
module hand_datapath #(
  parameter int CARD_MAX = 13
) (
  input  logic            slow_clock,
  input  logic            resetb,
  hand_datapath_if.slave  bus
);

  // Highest legal card code at the register width.
  localparam logic [3:0] CARD_MAX_C = 4'(CARD_MAX);

  // Slot indices into the load vector and card register file.
  localparam int SLOT_P1 = 0;
  localparam int SLOT_P2 = 1;
  localparam int SLOT_P3 = 2;
  localparam int SLOT_D1 = 3;
  localparam int SLOT_D2 = 4;
  localparam int SLOT_D3 = 5;

  // One state per expected load; DONE refuses everything until reset.
  typedef enum logic [2:0] {
    EXP_P1,
    EXP_D1,
    EXP_P2,
    EXP_D2,
    EXP_THIRD,
    EXP_D3,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] card_q [6];
  logic [2:0] dealt_q;
  logic       err_q;

  logic [5:0] load_vec;
  logic [5:0] allowed;
  logic       one_hot;
  logic       accept;
  logic       violation;
  logic [3:0] capture_card;

  // Gather the six strobes into one vector ordered by slot index.
  assign load_vec = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  // Exactly one strobe high: non-zero and a power of two.
  assign one_hot = (load_vec != 6'd0) &&
                   ((load_vec & (load_vec - 6'd1)) == 6'd0);

  // ---------------------------------------------------------------------
  // Card source
  // ---------------------------------------------------------------------
`ifdef HAND_INTERNAL_DEALER_EN
  logic [3:0] deal_ctr_q;

  // Free-running dealer counter cycling 1..CARD_MAX, advancing every edge.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      deal_ctr_q <= 4'd1;
    end else if (deal_ctr_q >= CARD_MAX_C) begin
      deal_ctr_q <= 4'd1;
    end else begin
      deal_ctr_q <= deal_ctr_q + 4'd1;
    end
  end

  assign capture_card = deal_ctr_q;
`else
  assign capture_card = bus.new_card;
`endif

  // ---------------------------------------------------------------------
  // Order FSM
  // ---------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= EXP_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Legal-load mask, accept/violation decode and next state.
  // NOTE: every output of this block is given a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    allowed   = 6'd0;
    accept    = 1'b0;
    violation = 1'b0;

    case (state_q)
      EXP_P1:    allowed[SLOT_P1] = 1'b1;
      EXP_D1:    allowed[SLOT_D1] = 1'b1;
      EXP_P2:    allowed[SLOT_P2] = 1'b1;
      EXP_D2:    allowed[SLOT_D2] = 1'b1;
      EXP_THIRD: begin
        allowed[SLOT_P3] = 1'b1;
        allowed[SLOT_D3] = 1'b1;
      end
      EXP_D3:    allowed[SLOT_D3] = 1'b1;
      default:   allowed = 6'd0;
    endcase

    accept    = one_hot && ((load_vec & ~allowed) == 6'd0);
    violation = (load_vec != 6'd0) && !accept;

    if (accept) begin
      case (state_q)
        EXP_P1:    state_d = EXP_D1;
        EXP_D1:    state_d = EXP_P2;
        EXP_P2:    state_d = EXP_D2;
        EXP_D2:    state_d = EXP_THIRD;
        // Player draws a third card, or stands and the dealer draws.
        EXP_THIRD: state_d = load_vec[SLOT_P3] ? EXP_D3 : DONE;
        EXP_D3:    state_d = DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Hand registers, dealt count and sticky error flag
  // ---------------------------------------------------------------------

  // Capture the card into the strobed slot on an accepted load.
  // NOTE: the six card registers are reset explicitly because 0 means
  // "empty" to both the display and the scorer; this is a register file,
  // not a RAM, so resetting it costs only flop reset pins.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) begin
        card_q[i] <= 4'd0;
      end
      dealt_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 6; i++) begin
          if (load_vec[i]) begin
            card_q[i] <= capture_card;
          end
        end
        dealt_q <= dealt_q + 3'd1;
      end
      if (violation) begin
        err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scoring (combinational from the registered cards only)
  // ---------------------------------------------------------------------

  // Baccarat value: 1..9 count at face value, court cards and any
  // illegal code (0 or above CARD_MAX) count as 0.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if ((code >= 4'd1) && (code <= 4'd9) && (code <= CARD_MAX_C)) begin
      return code;
    end
    return 4'd0;
  endfunction

  // Reduce a three-card sum (0..27) modulo 10.
  function automatic logic [3:0] mod10(input logic [4:0] sum);
    logic [4:0] r;
    if (sum >= 5'd20) begin
      r = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      r = sum - 5'd10;
    end else begin
      r = sum;
    end
    return r[3:0];
  endfunction

  logic [4:0] psum;
  logic [4:0] dsum;

  // Five-bit hand sums; empty slots are 0 and contribute nothing.
  always_comb begin
    psum = {1'b0, card_value(card_q[SLOT_P1])}
         + {1'b0, card_value(card_q[SLOT_P2])}
         + {1'b0, card_value(card_q[SLOT_P3])};
    dsum = {1'b0, card_value(card_q[SLOT_D1])}
         + {1'b0, card_value(card_q[SLOT_D2])}
         + {1'b0, card_value(card_q[SLOT_D3])};
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.pcard1_out   = card_q[SLOT_P1];
  assign bus.pcard2_out   = card_q[SLOT_P2];
  assign bus.pcard3_out   = card_q[SLOT_P3];
  assign bus.dcard1_out   = card_q[SLOT_D1];
  assign bus.dcard2_out   = card_q[SLOT_D2];
  assign bus.dcard3_out   = card_q[SLOT_D3];
  assign bus.pcard3       = card_q[SLOT_P3];
  assign bus.pscore       = mod10(psum);
  assign bus.dscore       = mod10(dsum);
  assign bus.cards_dealt  = dealt_q;
  assign bus.protocol_err = err_q;

endmodule : hand_datapath

// File: tb/tb_hand_datapath.sv
// ---------------------------------------------------------------------------
// tb_hand_datapath
//   Drives the hand datapath through complete hands, dealer-only third card,
//   order violations, simultaneous strobes, mid-hand reset, illegal card
//   codes and a random stretch. Each edge pushes the model's expected state
//   into a queue; the monitor pops and compares it just after the edge.
//   Scenario tasks add spot checks of hand-computed values.
// ---------------------------------------------------------------------------
module tb_hand_datapath;

  localparam logic [5:0] LD_P1 = 6'b000001;
  localparam logic [5:0] LD_P2 = 6'b000010;
  localparam logic [5:0] LD_P3 = 6'b000100;
  localparam logic [5:0] LD_D1 = 6'b001000;
  localparam logic [5:0] LD_D2 = 6'b010000;
  localparam logic [5:0] LD_D3 = 6'b100000;
  localparam logic [5:0] LD_NONE = 6'b000000;

  logic slow_clock;
  logic resetb;

  hand_datapath_if bus ();

  hand_datapath #(.CARD_MAX(13)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus.slave)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  int checks   = 0;
  int failures = 0;

  // Expected post-edge snapshot.
  typedef struct {
    string            tag;
    logic [5:0][3:0]  cards;
    logic [3:0]       pscore;
    logic [3:0]       dscore;
    logic [2:0]       dealt;
    logic             err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state. Position: 0 P1, 1 D1, 2 P2, 3 D2, 4 third, 5 D3, 6 done.
  int              m_pos;
  logic [5:0][3:0] m_cards;
  logic [2:0]      m_dealt;
  logic            m_err;
  logic [3:0]      m_ctr;

  function automatic logic [5:0] legal_mask(input int pos);
    case (pos)
      0:       return LD_P1;
      1:       return LD_D1;
      2:       return LD_P2;
      3:       return LD_D2;
      4:       return LD_P3 | LD_D3;
      5:       return LD_D3;
      default: return LD_NONE;
    endcase
  endfunction

  function automatic int value_of(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
  endfunction

  task automatic model_edge(input logic rst_n, input logic [5:0] ld, input logic [3:0] card);
    logic [3:0] src;
    if (!rst_n) begin
      m_cards = '0;
      m_pos   = 0;
      m_dealt = 3'd0;
      m_err   = 1'b0;
      m_ctr   = 4'd1;
    end else begin
`ifdef HAND_INTERNAL_DEALER_EN
      src = m_ctr;
`else
      src = card;
`endif
      if (ld != LD_NONE) begin
        if ($countones(ld) == 1 && (ld & legal_mask(m_pos)) != LD_NONE) begin
          for (int i = 0; i < 6; i++) if (ld[i]) m_cards[i] = src;
          m_dealt = m_dealt + 3'd1;
          if (m_pos == 4) m_pos = (ld == LD_P3) ? 5 : 6;
          else            m_pos = m_pos + 1;
        end else begin
          m_err = 1'b1;
        end
      end
      m_ctr = (m_ctr == 4'd13) ? 4'd1 : m_ctr + 4'd1;
    end
  endtask

  // One clock edge: drive at negedge, update model, push expectation,
  // then pop and compare one time unit after the rising edge.
  task automatic cycle(input logic rst_n, input logic [5:0] ld, input logic [3:0] card,
                       input string tag);
    exp_t e;
    exp_t g;
    logic [5:0][3:0] act;
    @(negedge slow_clock);
    resetb          = rst_n;
    bus.new_card    = card;
    bus.load_pcard1 = ld[0];
    bus.load_pcard2 = ld[1];
    bus.load_pcard3 = ld[2];
    bus.load_dcard1 = ld[3];
    bus.load_dcard2 = ld[4];
    bus.load_dcard3 = ld[5];
    model_edge(rst_n, ld, card);
    e.tag    = tag;
    e.cards  = m_cards;
    e.pscore = 4'((value_of(m_cards[0]) + value_of(m_cards[1]) + value_of(m_cards[2])) % 10);
    e.dscore = 4'((value_of(m_cards[3]) + value_of(m_cards[4]) + value_of(m_cards[5])) % 10);
    e.dealt  = m_dealt;
    e.err    = m_err;
    sb_q.push_back(e);
    @(posedge slow_clock);
    #1;
    g   = sb_q.pop_front();
    act = {bus.dcard3_out, bus.dcard2_out, bus.dcard1_out,
           bus.pcard3_out, bus.pcard2_out, bus.pcard1_out};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (act[i] !== g.cards[i]) begin
        failures++;
        $display("FAIL %s card[%0d] got=%0d exp=%0d", g.tag, i, act[i], g.cards[i]);
      end
    end
    checks++;
    if (bus.pcard3 !== g.cards[2]) begin
      failures++;
      $display("FAIL %s pcard3 got=%0d exp=%0d", g.tag, bus.pcard3, g.cards[2]);
    end
    checks++;
    if (bus.pscore !== g.pscore) begin
      failures++;
      $display("FAIL %s pscore got=%0d exp=%0d", g.tag, bus.pscore, g.pscore);
    end
    checks++;
    if (bus.dscore !== g.dscore) begin
      failures++;
      $display("FAIL %s dscore got=%0d exp=%0d", g.tag, bus.dscore, g.dscore);
    end
    checks++;
    if (bus.cards_dealt !== g.dealt) begin
      failures++;
      $display("FAIL %s cards_dealt got=%0d exp=%0d", g.tag, bus.cards_dealt, g.dealt);
    end
    checks++;
    if (bus.protocol_err !== g.err) begin
      failures++;
      $display("FAIL %s protocol_err got=%0b exp=%0b", g.tag, bus.protocol_err, g.err);
    end
  endtask

  // Reset must win over a load in the same cycle.
  task automatic test_reset();
    cycle(1'b0, LD_P1, 4'd7, "reset_with_load");
    cycle(1'b0, LD_NONE, 4'd0, "reset_idle");
    checks++;
    if (bus.pcard1_out !== 4'd0 || bus.cards_dealt !== 3'd0 || bus.protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got p1=%0d dealt=%0d err=%0b exp=0/0/0",
               bus.pcard1_out, bus.cards_dealt, bus.protocol_err);
    end
  endtask

`ifndef HAND_INTERNAL_DEALER_EN
  task automatic test_full_hand();
    cycle(1'b0, LD_NONE, 4'd0, "fh_reset");
    cycle(1'b1, LD_P1, 4'd5,  "fh_p1");
    cycle(1'b1, LD_D1, 4'd3,  "fh_d1");
    cycle(1'b1, LD_P2, 4'd13, "fh_p2");
    cycle(1'b1, LD_D2, 4'd4,  "fh_d2");
    checks++;
    if (bus.pscore !== 4'd5 || bus.dscore !== 4'd7 || bus.cards_dealt !== 3'd4 ||
        bus.protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL fh_four got ps=%0d ds=%0d dealt=%0d err=%0b exp=5/7/4/0",
               bus.pscore, bus.dscore, bus.cards_dealt, bus.protocol_err);
    end
    cycle(1'b1, LD_P3, 4'd9, "fh_p3");
    cycle(1'b1, LD_D3, 4'd8, "fh_d3");
    checks++;
    if (bus.pscore !== 4'd4 || bus.dscore !== 4'd5 || bus.pcard3 !== 4'd9 ||
        bus.cards_dealt !== 3'd6) begin
      failures++;
      $display("FAIL fh_six got ps=%0d ds=%0d pc3=%0d dealt=%0d exp=4/5/9/6",
               bus.pscore, bus.dscore, bus.pcard3, bus.cards_dealt);
    end
    cycle(1'b1, LD_P1, 4'd1, "fh_extra");
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.pcard1_out !== 4'd5 || bus.cards_dealt !== 3'd6) begin
      failures++;
      $display("FAIL fh_extra got err=%0b p1=%0d dealt=%0d exp=1/5/6",
               bus.protocol_err, bus.pcard1_out, bus.cards_dealt);
    end
  endtask

  task automatic test_dealer_draw();
    cycle(1'b0, LD_NONE, 4'd0, "dd_reset");
    cycle(1'b1, LD_P1, 4'd5, "dd_p1");
    cycle(1'b1, LD_D1, 4'd3, "dd_d1");
    cycle(1'b1, LD_P2, 4'd2, "dd_p2");
    cycle(1'b1, LD_D2, 4'd4, "dd_d2");
    cycle(1'b1, LD_D3, 4'd6, "dd_d3");
    checks++;
    if (bus.dcard3_out !== 4'd6 || bus.cards_dealt !== 3'd5 || bus.dscore !== 4'd3 ||
        bus.protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL dd_d3 got d3=%0d dealt=%0d ds=%0d err=%0b exp=6/5/3/0",
               bus.dcard3_out, bus.cards_dealt, bus.dscore, bus.protocol_err);
    end
    cycle(1'b1, LD_P3, 4'd2, "dd_late_p3");
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.pcard3 !== 4'd0) begin
      failures++;
      $display("FAIL dd_late_p3 got err=%0b pc3=%0d exp=1/0", bus.protocol_err, bus.pcard3);
    end
  endtask

  task automatic test_out_of_order();
    cycle(1'b0, LD_NONE, 4'd0, "oo_reset");
    cycle(1'b1, LD_D1, 4'd9, "oo_d1_first");
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.dcard1_out !== 4'd0 || bus.cards_dealt !== 3'd0) begin
      failures++;
      $display("FAIL oo_d1_first got err=%0b d1=%0d dealt=%0d exp=1/0/0",
               bus.protocol_err, bus.dcard1_out, bus.cards_dealt);
    end
    cycle(1'b1, LD_P1, 4'd2, "oo_p1");
    checks++;
    if (bus.pcard1_out !== 4'd2 || bus.cards_dealt !== 3'd1 || bus.protocol_err !== 1'b1) begin
      failures++;
      $display("FAIL oo_p1 got p1=%0d dealt=%0d err=%0b exp=2/1/1",
               bus.pcard1_out, bus.cards_dealt, bus.protocol_err);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    cycle(1'b0, LD_NONE, 4'd0, "sim_reset");
    cycle(1'b1, LD_P1 | LD_D1, 4'd7, "sim_two");
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.pcard1_out !== 4'd0 || bus.dcard1_out !== 4'd0) begin
      failures++;
      $display("FAIL sim_two got err=%0b p1=%0d d1=%0d exp=1/0/0",
               bus.protocol_err, bus.pcard1_out, bus.dcard1_out);
    end
    cycle(1'b1, LD_P1, 4'd6, "mr_p1");
    cycle(1'b1, LD_D1, 4'd7, "mr_d1");
    cycle(1'b1, LD_P2, 4'd1, "mr_p2");
    cycle(1'b0, LD_NONE, 4'd0, "mr_reset");
    checks++;
    if (bus.pcard1_out !== 4'd0 || bus.dcard1_out !== 4'd0 || bus.pscore !== 4'd0 ||
        bus.dscore !== 4'd0 || bus.cards_dealt !== 3'd0 || bus.protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL mr_reset got p1=%0d d1=%0d ps=%0d ds=%0d dealt=%0d err=%0b exp=all 0",
               bus.pcard1_out, bus.dcard1_out, bus.pscore, bus.dscore,
               bus.cards_dealt, bus.protocol_err);
    end
  endtask

  // Codes 0 and above CARD_MAX are stored and counted but score 0.
  task automatic test_illegal_codes();
    cycle(1'b0, LD_NONE, 4'd0, "ic_reset");
    cycle(1'b1, LD_P1, 4'd0,  "ic_p1_zero");
    cycle(1'b1, LD_D1, 4'd15, "ic_d1_15");
    cycle(1'b1, LD_P2, 4'd11, "ic_p2_11");
    cycle(1'b1, LD_D2, 4'd14, "ic_d2_14");
    checks++;
    if (bus.dcard1_out !== 4'd15 || bus.cards_dealt !== 3'd4 || bus.pscore !== 4'd0 ||
        bus.dscore !== 4'd0 || bus.protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL ic_codes got d1=%0d dealt=%0d ps=%0d ds=%0d err=%0b exp=15/4/0/0/0",
               bus.dcard1_out, bus.cards_dealt, bus.pscore, bus.dscore, bus.protocol_err);
    end
  endtask
`else
  task automatic test_internal_dealer();
    cycle(1'b0, LD_NONE, 4'd0, "id_reset");
    cycle(1'b1, LD_P1, 4'd9, "id_p1");
    checks++;
    if (bus.pcard1_out !== 4'd1) begin
      failures++;
      $display("FAIL id_p1 got=%0d exp=1", bus.pcard1_out);
    end
    cycle(1'b1, LD_D1, 4'd9, "id_d1");
    cycle(1'b1, LD_P2, 4'd9, "id_p2");
    cycle(1'b1, LD_D2, 4'd9, "id_d2");
    checks++;
    if (bus.dcard1_out !== 4'd2 || bus.pcard2_out !== 4'd3 || bus.dcard2_out !== 4'd4 ||
        bus.pscore !== 4'd4 || bus.dscore !== 4'd6) begin
      failures++;
      $display("FAIL id_hand got d1=%0d p2=%0d d2=%0d ps=%0d ds=%0d exp=2/3/4/4/6",
               bus.dcard1_out, bus.pcard2_out, bus.dcard2_out, bus.pscore, bus.dscore);
    end
  endtask
`endif

  // Random mix of single legal-ish loads, double loads, idles and resets.
  task automatic test_random();
    logic [5:0] ld;
    int         r;
    cycle(1'b0, LD_NONE, 4'd0, "rnd_reset");
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)      ld = 6'(1 << $urandom_range(0, 5));
      else if (r < 15) ld = 6'($urandom_range(0, 63));
      else             ld = LD_NONE;
      if (r == 19) cycle(1'b0, ld, 4'($urandom_range(0, 15)), "rnd");
      else         cycle(1'b1, ld, 4'($urandom_range(0, 15)), "rnd");
    end
  endtask

  initial begin
    resetb          = 1'b0;
    bus.new_card    = 4'd0;
    bus.load_pcard1 = 1'b0;
    bus.load_pcard2 = 1'b0;
    bus.load_pcard3 = 1'b0;
    bus.load_dcard1 = 1'b0;
    bus.load_dcard2 = 1'b0;
    bus.load_dcard3 = 1'b0;
    m_pos   = 0;
    m_cards = '0;
    m_dealt = 3'd0;
    m_err   = 1'b0;
    m_ctr   = 4'd1;

    test_reset();
`ifndef HAND_INTERNAL_DEALER_EN
    test_full_hand();
    test_dealer_draw();
    test_out_of_order();
    test_simultaneous_and_reset();
    test_illegal_codes();
`else
    test_internal_dealer();
`endif
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hand_datapath

// File: doc/hand_datapath.md
Name: hand_datapath

Overview:
- Responder to the baccarat dealing controller.
- Captures one card per load strobe into six hand registers (player 1-3, dealer 1-3).
- Returns pscore, dscore and pcard3 to the controller, and drives the card values to the HEX display logic.
- Enforces the legal dealing order and flags any violation.

Parameters:
- CARD_MAX, 13, highest legal card code; codes 1..CARD_MAX are legal, 0 means empty.

Ports:
- slow_clock  input  1  system clock; all state updates on its rising edge.
- resetb  input  1  synchronous, active-low reset.
- new_card  input  4  card code presented by the card source; sampled on the load edge.
- load_pcard1  input  1  capture new_card into player card 1.
- load_pcard2  input  1  capture into player card 2.
- load_pcard3  input  1  capture into player card 3.
- load_dcard1  input  1  capture into dealer card 1.
- load_dcard2  input  1  capture into dealer card 2.
- load_dcard3  input  1  capture into dealer card 3.
- pcard1_out, pcard2_out, pcard3_out  output  4 each  registered player cards (for display).
- dcard1_out, dcard2_out, dcard3_out  output  4 each  registered dealer cards.
- pcard3  output  4  raw player card 3 code, same value as pcard3_out, sent to the controller.
- pscore  output  4  player hand score, 0..9.
- dscore  output  4  dealer hand score, 0..9.
- cards_dealt  output  3  number of cards accepted this hand, 0..6.
- protocol_err  output  1  sticky dealing-order violation flag.

Behaviour:
- Reset (resetb=0 at an edge):
  - all six card registers = 0;
  - cards_dealt = 0, protocol_err = 0, order state = EXP_P1;
  - pscore and dscore therefore read 0.
  - Reset overrides any load asserted in the same cycle.
- Order FSM states, one per expected load: EXP_P1 -> EXP_D1 -> EXP_P2 -> EXP_D2 -> EXP_THIRD -> EXP_D3 -> DONE.
- Accept rules:
  - exactly one load_* high, and it matches the current state -> write new_card to that register, cards_dealt +1, advance.
  - In EXP_THIRD: load_pcard3 -> EXP_D3; load_dcard3 -> DONE (dealer draws, player stood).
  - In EXP_D3: only load_dcard3 is accepted -> DONE.
  - DONE: any load is a violation.
- Violation (two or more loads in one cycle, or a load not legal in the current state):
  - no register written; state and cards_dealt unchanged;
  - protocol_err set on that edge and held until reset.
  - After protocol_err=1, legal loads are still accepted.
- Card capture:
  - Codes 1..CARD_MAX are stored as given.
  - Codes 0 or >CARD_MAX are still stored.
  - Such codes are counted as dealt but valued 0 for scoring.
- Card value for scoring: codes 1..9 = face value; 10..CARD_MAX = 0; illegal codes = 0.
- Score:
  - Combinational from the registered cards; never from new_card.
  - Computed as a 5-bit sum of the three values (max 27), then mod 10, giving a 4-bit result.
  - A newly loaded card affects the score in the cycle after its load edge (one-cycle latency).
- Empty registers (0) contribute 0, so a two-card hand scores correctly before any third card.
- Next hand: only resetb clears the hand; there is no auto-clear in DONE.

Optional Feature:
- Macro: HAND_INTERNAL_DEALER_EN.
- Defined:
  - new_card is ignored (port kept, unused).
  - An internal 4-bit counter runs 1,2,..,CARD_MAX,1,... and advances every slow_clock edge.
  - Reset sets the counter to 1.
  - Each accepted load captures the current counter value.
- Undefined: cards come from new_card, and no counter is built.

Test Plan:
- Reset, then legal loads P1=5, D1=3, P2=13, D2=4 -> pscore=5, dscore=7, cards_dealt=4, protocol_err=0.
- Continue with P3=9, then D3=8 -> pscore=4 (14 mod 10), dscore=5, pcard3=9, cards_dealt=6; any further load -> protocol_err=1, cards unchanged.
- After the first four cards, load_dcard3 with card 6 -> accepted, state DONE; a following load_pcard3 -> protocol_err=1, pcard3 stays 0.
- Out of order from reset: load_dcard1 first -> protocol_err=1, dcard1_out=0, cards_dealt=0; then load_pcard1 with card 2 -> accepted, pcard1_out=2.
- Simultaneous load_pcard1 and load_dcard1 -> nothing written, protocol_err=1; reset mid-hand (after 3 cards) -> all cards, scores and cards_dealt return to 0, protocol_err=0.
- With HAND_INTERNAL_DEALER_EN: release reset, then assert load_pcard1 on the first edge -> pcard1_out=1; hold loads legal each cycle -> dealt values 1,2,3,4 and pscore=4, dscore=6.
